// File: rtl/pool_window_feeder.sv
// ----------------------------------------------------------------------------
// pool_window_feeder
//
// Collects SIZE streamed fixed-point words into a window register, hands the
// window to an external running-max pooler (start pulse, then enable while it
// iterates), and captures the pooler's result into a one-deep output buffer
// with a valid/ready handshake. A new window may fill while the previous
// result is still waiting downstream.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_data/in_valid   streamed input word
//   in_ready           input accepted this cycle (only while filling)
//   win[SIZE]          window words presented to the pooler
//   win_en, win_load   pooler enable / start pulse
//   pool_done          pooler finished iterating over the window
//   pool_result        pooler's running-max output
//   out_data/out_valid pooled result to downstream
//   out_ready          downstream accepts out_data
// ----------------------------------------------------------------------------
module pool_window_feeder #(
    parameter int unsigned IL   = 4,
    parameter int unsigned FL   = 16,
    parameter int unsigned SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IL+FL-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [IL+FL-1:0]     win [SIZE],
    output logic                 win_en,
    output logic                 win_load,
    input  logic                 pool_done,
    input  logic [IL+FL-1:0]     pool_result,
    output logic [IL+FL-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned W    = IL + FL;
    localparam int unsigned PtrW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        StFill,
        StLoad,
        StPool,
        StCapt
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0]    win_q [SIZE];
    logic [W-1:0]    win_d [SIZE];
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;

    // Pooler-facing strobes and input ready depend on state only.
    always_comb begin
        in_ready = 1'b0;
        win_en   = 1'b0;
        win_load = 1'b0;
        unique case (state_q)
            StFill: in_ready = 1'b1;
            StLoad: begin
                win_en   = 1'b1;
                win_load = 1'b1;
            end
            StPool: win_en = 1'b1;
            StCapt: ;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        win_d       = win_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        // Downstream pop; a capture on the same edge overrides below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StFill: begin
                if (in_valid) begin
                    win_d[wr_ptr_q] = in_data;
                    wr_ptr_d        = wr_ptr_q + PtrW'(1);
                    if (wr_ptr_q == PtrW'(SIZE - 1)) begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: state_d = StPool;
            StPool: begin
                if (pool_done) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                // Capture only when the output buffer is empty or emptying now.
                if (!out_valid_q || out_ready) begin
                    out_data_d  = pool_result;
                    out_valid_d = 1'b1;
                    state_d     = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            wr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < int'(SIZE); i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < int'(SIZE); i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign win       = win_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// ----------------------------------------------------------------------------
// Bench for pool_window_feeder: a small running-max pooler stands in for the
// pooling stage, a transaction-level model predicts every visible output, and
// directed windows pin the model with hand-computed results.
// ----------------------------------------------------------------------------
module tb_pool_window_feeder;

    localparam int unsigned IL   = 4;
    localparam int unsigned FL   = 16;
    localparam int unsigned SIZE = 4;
    localparam int unsigned W    = IL + FL;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] win [SIZE];
    logic         win_en;
    logic         win_load;
    logic         pool_done;
    logic [W-1:0] pool_result;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;

    pool_window_feeder #(
        .IL  (IL),
        .FL  (FL),
        .SIZE(SIZE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .win        (win),
        .win_en     (win_en),
        .win_load   (win_load),
        .pool_done  (pool_done),
        .pool_result(pool_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Conforming pooler: start on win_load, one word per enabled cycle,
    // done on its SIZE-th enabled cycle, result held while win_en is low.
    logic         p_busy;
    int unsigned  p_cnt;
    logic [W-1:0] p_acc;

    assign pool_done   = p_busy && (p_cnt == SIZE - 1);
    assign pool_result = p_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_busy <= 1'b0;
            p_cnt  <= 0;
            p_acc  <= '0;
        end else if (win_load) begin
            p_busy <= 1'b1;
            p_cnt  <= 0;
            p_acc  <= '0;
        end else if (win_en && p_busy) begin
            if (win[p_cnt] > p_acc) p_acc <= win[p_cnt];
            p_cnt <= p_cnt + 1;
            if (pool_done) p_busy <= 1'b0;
        end
    end

    // Transaction model: words accepted only while not busy; a full window
    // makes the block busy; the result (plain max of the window) is captured
    // SIZE+2 edges after the last accept, or later if the output buffer is full.
    logic [W-1:0] m_win [SIZE] = '{default: '0};
    int           m_cnt  = 0;
    int           m_age  = 0;
    bit           m_busy = 1'b0;
    bit           m_ov   = 1'b0;
    logic [W-1:0] m_od   = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cnt  = 0;
            m_age  = 0;
            m_busy = 1'b0;
            m_ov   = 1'b0;
            m_od   = '0;
            foreach (m_win[i]) m_win[i] = '0;
        end else begin
            bit           acc;
            bit           cap;
            logic [W-1:0] mx;
            acc = !m_busy && in_valid;
            cap = m_busy && (m_age >= int'(SIZE) + 1) && (!m_ov || out_ready);
            if (m_ov && out_ready) m_ov = 1'b0;
            if (cap) begin
                mx = '0;
                foreach (m_win[i]) if (m_win[i] > mx) mx = m_win[i];
                m_od   = mx;
                m_ov   = 1'b1;
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_age++;
            end
            if (acc) begin
                m_win[m_cnt] = in_data;
                if (m_cnt == int'(SIZE) - 1) begin
                    m_cnt  = 0;
                    m_busy = 1'b1;
                    m_age  = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("in_ready", in_ready, m_busy ? 0 : 1);
            check("win_load", win_load, (m_busy && m_age == 0) ? 1 : 0);
            check("win_en", win_en, (m_busy && m_age <= int'(SIZE)) ? 1 : 0);
            check("out_valid", out_valid, m_ov ? 1 : 0);
            check("out_data", out_data, m_od);
            for (int i = 0; i < int'(SIZE); i++) begin
                check("win", win[i], m_win[i]);
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accept", ok, 1);
    endtask

    task automatic wait_result(output logic [W-1:0] d, output int t);
        bit seen;
        seen = 1'b0;
        d    = '0;
        t    = -1;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                d    = out_data;
                t    = cyc;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("result_seen", out_valid, 1);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] got;
        int           t0;
        int           t1;
        int           nl;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_win_en", win_en, 0);
        check("rst_win_load", win_load, 0);
        for (int i = 0; i < int'(SIZE); i++) check("rst_win", win[i], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic window, latency
        out_ready = 1'b1;
        send(20'h00010);
        send(20'h00300);
        send(20'h00020);
        send(20'h00005);
        t0 = cyc;
        wait_result(d, t1);
        check("lat_data", d, 20'h00300);
        check("lat_edges", t1 - t0, SIZE + 2);
        @(posedge clk);
        #1;
        check("lat_one_cycle", out_valid, 0);

        // Extremes
        send(20'hFFFFF);
        send(20'h00000);
        send(20'h00000);
        send(20'h00000);
        wait_result(d, t1);
        check("max_ffff", d, 20'hFFFFF);
        repeat (SIZE) send(20'h00000);
        wait_result(d, t1);
        check("zero_data", d, 20'h00000);
        check("zero_valid", out_valid, 1);
        @(posedge clk);
        #1;

        // Two windows against a stalled output
        out_ready = 1'b0;
        send(20'h00011);
        send(20'h00022);
        send(20'h00099);
        send(20'h00033);
        send(20'h00007);
        send(20'h01234);
        send(20'h00005);
        send(20'h00006);
        repeat (SIZE + 4) @(posedge clk);
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_valid", out_valid, 1);
        check("stall_first", out_data, 20'h00099);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_second_valid", out_valid, 1);
        check("stall_second", out_data, 20'h01234);
        @(posedge clk);
        #1;
        check("stall_drained", out_valid, 0);

        // Gappy input
        nl  = 0;
        got = '0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = W'(i * 32 + 1);
            @(posedge clk);
            #1;
            if (win_load) nl++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (win_load) nl++;
            if (out_valid) got = out_data;
        end
        check("gap_load_pulses", nl, 1);
        check("gap_result", got, 20'h000C1);

        // Reset mid-window
        send(20'h00500);
        send(20'h00600);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_win0", win[0], 0);
        check("mid_rst_win1", win[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(20'h00040);
        send(20'h00030);
        send(20'h00020);
        send(20'h00010);
        wait_result(d, t1);
        check("post_rst_result", d, 20'h00040);
        @(posedge clk);
        #1;

        // in_valid held high while pooling
        send(20'h00001);
        send(20'h00002);
        send(20'h00003);
        send(20'h00004);
        in_valid = 1'b1;
        in_data  = 20'hFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_in_ready", in_ready, 0);
            check("hold_win0", win[0], 20'h00001);
        end
        in_valid = 1'b0;
        wait_result(d, t1);
        check("hold_result", d, 20'h00004);
        @(posedge clk);
        #1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 3) != 0;
            in_data   = ($urandom % 4 == 0) ? W'($urandom % 8) : W'($urandom);
            out_ready = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("final_drained", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
